// File: rtl/mem_arbiter_if.sv
// Bus bundle between the IFU/LSU masters, the memory arbiter and the SoC memory port.
// The slave modport is the arbiter's view; the master modport is the master and memory side.
interface mem_arbiter_if;
  logic        ifu_reqValid;
  logic [31:0] ifu_addr;
  logic        ifu_respValid;
  logic [31:0] ifu_rdata;

  logic        lsu_reqValid;
  logic        lsu_lock;
  logic [31:0] lsu_addr;
  logic [31:0] lsu_wdata;
  logic [1:0]  lsu_size;
  logic        lsu_wen;
  logic [3:0]  lsu_wmask;
  logic        lsu_respValid;
  logic [31:0] lsu_rdata;

  logic        mem_reqValid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [1:0]  mem_size;
  logic        mem_wen;
  logic [3:0]  mem_wmask;
  logic        mem_respValid;
  logic [31:0] mem_rdata;

  logic        bus_err;

  modport slave (
    input  ifu_reqValid, ifu_addr,
    input  lsu_reqValid, lsu_lock, lsu_addr, lsu_wdata, lsu_size, lsu_wen, lsu_wmask,
    input  mem_respValid, mem_rdata,
    output ifu_respValid, ifu_rdata, lsu_respValid, lsu_rdata,
    output mem_reqValid, mem_addr, mem_wdata, mem_size, mem_wen, mem_wmask,
    output bus_err
  );

  modport master (
    output ifu_reqValid, ifu_addr,
    output lsu_reqValid, lsu_lock, lsu_addr, lsu_wdata, lsu_size, lsu_wen, lsu_wmask,
    output mem_respValid, mem_rdata,
    input  ifu_respValid, ifu_rdata, lsu_respValid, lsu_rdata,
    input  mem_reqValid, mem_addr, mem_wdata, mem_size, mem_wen, mem_wmask,
    input  bus_err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one memory port between IFU and LSU: one transaction in flight, LSU priority with a
// fairness turn bit, LSU lock for split accesses, and a watchdog that errors out hung requests.
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TO_W    = 8
) (
  input  logic         clock,
  input  logic         reset,
  mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BUSY_IFU, BUSY_LSU, LOCK_LSU} state_t;

  localparam logic [TO_W-1:0] WD_LAST  = TO_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic [31:0]     ERR_DATA = 32'hDEAD_BEEF;

  state_t          state;
  state_t          done_state;
  logic            turn;
  logic [TO_W-1:0] wd_cnt;
  logic            win_lsu, win_ifu, sel_lsu, active, waiting;
  logic            wd_fire, resp;
  logic [31:0]     rsp_data;

  // active: a request is on the memory port this cycle; waiting: it was granted in an earlier cycle
  always_comb begin
    win_lsu = 1'b0;
    win_ifu = 1'b0;
    sel_lsu = 1'b0;
    active  = 1'b0;
    waiting = 1'b0;
    case (state)
      IDLE: begin
        win_lsu = !reset && bus.lsu_reqValid && (!bus.ifu_reqValid || !turn);
        win_ifu = !reset && bus.ifu_reqValid && !win_lsu;
        sel_lsu = win_lsu;
        active  = win_lsu || win_ifu;
      end
      BUSY_IFU: begin
        active  = 1'b1;
        waiting = 1'b1;
      end
      BUSY_LSU: begin
        sel_lsu = 1'b1;
        active  = 1'b1;
        waiting = 1'b1;
      end
      default: begin
        sel_lsu = 1'b1;
        active  = bus.lsu_reqValid;
        waiting = bus.lsu_reqValid;
      end
    endcase
  end

  // A real response in the timeout cycle wins over the watchdog
  assign wd_fire    = (TIMEOUT != 0) && waiting && !bus.mem_respValid && (wd_cnt == WD_LAST);
  assign resp       = active && (bus.mem_respValid || wd_fire);
  assign done_state = (sel_lsu && bus.lsu_lock && !wd_fire) ? LOCK_LSU : IDLE;
  assign rsp_data   = wd_fire ? ERR_DATA : bus.mem_rdata;

  assign bus.mem_reqValid  = active;
  assign bus.mem_addr      = !active ? '0 : (sel_lsu ? bus.lsu_addr : bus.ifu_addr);
  assign bus.mem_wdata     = (active && sel_lsu) ? bus.lsu_wdata : '0;
  assign bus.mem_size      = !active ? 2'b00 : (sel_lsu ? bus.lsu_size : 2'b10);
  assign bus.mem_wen       = active && sel_lsu && bus.lsu_wen;
  assign bus.mem_wmask     = !active ? 4'h0 : (sel_lsu ? bus.lsu_wmask : 4'hF);

  assign bus.ifu_respValid = resp && !sel_lsu;
  assign bus.ifu_rdata     = (resp && !sel_lsu) ? rsp_data : '0;
  assign bus.lsu_respValid = resp && sel_lsu;
  assign bus.lsu_rdata     = (resp && sel_lsu) ? rsp_data : '0;
  assign bus.bus_err       = wd_fire;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      turn   <= 1'b0;
      wd_cnt <= '0;
    end else begin
      wd_cnt <= (waiting && !resp) ? wd_cnt + 1'b1 : '0;

      // IFU gets the next tie after the LSU finishes in front of it
      if (resp && sel_lsu && bus.ifu_reqValid) turn <= 1'b1;
      else if (resp && !sel_lsu)               turn <= 1'b0;

      case (state)
        IDLE: begin
          if (resp)        state <= done_state;
          else if (active) state <= win_lsu ? BUSY_LSU : BUSY_IFU;
        end
        BUSY_IFU, BUSY_LSU: begin
          if (resp) state <= done_state;
        end
        default: begin
          if (resp)                  state <= done_state;
          else if (bus.lsu_reqValid) state <= BUSY_LSU;
          else if (!bus.lsu_lock)    state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter: masters and memory are modelled here, a
// transaction-level model predicts grants, routing and watchdog completions.
module tb_mem_arbiter;
  localparam int TIMEOUT = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  mem_arbiter_if bus();
  mem_arbiter #(.TIMEOUT(TIMEOUT), .TO_W(8)) dut (.clock(clock), .reset(reset), .bus(bus));

  int checks = 0, failures = 0, cyc = 0;
  // 0: random latency 0..3, 1: zero latency, 2: never respond, 3: manual, 4: fixed latency 3
  int   lat_mode = 0;
  logic man_resp = 1'b0;
  bit   mon_en   = 1'b0;
  logic [31:0] ifu_q[$], lsu_q[$];
  bit   seq[$];
  int   ifu_resp_n = 0, lsu_resp_n = 0, ifu_seen = 0, lsu_seen = 0;
  bit   ifu_pend = 1'b0, lsu_pend = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] exp_data(input logic [31:0] a);
    return (lat_mode == 2) ? 32'hDEAD_BEEF : mem_data(a);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory: picks a latency per transaction and answers with data derived from the address
  initial begin : mem_model
    int lat, cnt;
    bit busy;
    busy = 1'b0; lat = 0; cnt = 0;
    bus.mem_respValid = 1'b0;
    bus.mem_rdata     = '0;
    forever begin
      @(negedge clock);
      bus.mem_respValid = 1'b0;
      bus.mem_rdata     = '0;
      if (reset) begin
        busy = 1'b0;
        continue;
      end
      if (lat_mode == 3) begin
        bus.mem_respValid = man_resp;
        bus.mem_rdata     = man_resp ? 32'h1234_5678 : 32'h0;
        continue;
      end
      if (bus.mem_reqValid && lat_mode != 2) begin
        if (!busy) begin
          busy = 1'b1;
          cnt  = 0;
          lat  = (lat_mode == 1) ? 0 : (lat_mode == 4) ? 3 : int'($urandom_range(0, 3));
        end
        if (cnt == lat) begin
          bus.mem_respValid = 1'b1;
          bus.mem_rdata     = mem_data(bus.mem_addr);
          busy = 1'b0;
        end else cnt++;
      end
    end
  end

  // Monitor: transaction-level model of who owns the port and when it must complete
  initial begin : monitor
    bit in_flight, owner_lsu, locked, owed, exp_active, exp_lsu, exp_resp;
    int waitc;
    logic [31:0] exp_d;
    in_flight = 0; owner_lsu = 0; locked = 0; owed = 0; waitc = 0;
    forever begin
      @(negedge clock); #2;
      if (reset || !mon_en) begin
        in_flight = 0; locked = 0; owed = 0; waitc = 0;
        continue;
      end
      if (in_flight) begin
        exp_active = 1'b1; exp_lsu = owner_lsu; waitc++;
      end else begin
        waitc = 0;
        if (locked) begin
          exp_lsu = 1'b1; exp_active = bus.lsu_reqValid;
        end else begin
          exp_lsu    = bus.lsu_reqValid && (!bus.ifu_reqValid || !owed);
          exp_active = exp_lsu || bus.ifu_reqValid;
        end
      end
      check("mem_reqValid", 32'(bus.mem_reqValid), 32'(exp_active));
      if (exp_active) begin
        check("mem_addr", bus.mem_addr, exp_lsu ? bus.lsu_addr : bus.ifu_addr);
        check("mem_ctl", {25'd0, bus.mem_size, bus.mem_wen, bus.mem_wmask},
              exp_lsu ? {25'd0, bus.lsu_size, bus.lsu_wen, bus.lsu_wmask} : {25'd0, 2'b10, 1'b0, 4'hF});
        check("mem_wdata", bus.mem_wdata, exp_lsu ? bus.lsu_wdata : 32'd0);
      end
      exp_resp = exp_active && ((lat_mode == 2) ? (waitc == TIMEOUT) : bus.mem_respValid);
      check("resp_route", {29'd0, bus.ifu_respValid, bus.lsu_respValid, bus.bus_err},
            {29'd0, exp_resp && !exp_lsu, exp_resp && exp_lsu, exp_resp && (lat_mode == 2)});

      if (bus.ifu_respValid) begin
        seq.push_back(1'b0); ifu_resp_n++;
        if (ifu_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL ifu_unexpected: got ifu_respValid=1 expected no outstanding fetch (cycle %0d)", cyc);
        end else begin
          exp_d = ifu_q.pop_front();
          check("ifu_rdata", bus.ifu_rdata, exp_d);
        end
      end else check("ifu_rdata_idle", bus.ifu_rdata, 32'd0);

      if (bus.lsu_respValid) begin
        seq.push_back(1'b1); lsu_resp_n++;
        if (lsu_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL lsu_unexpected: got lsu_respValid=1 expected no outstanding access (cycle %0d)", cyc);
        end else begin
          exp_d = lsu_q.pop_front();
          check("lsu_rdata", bus.lsu_rdata, exp_d);
        end
      end else check("lsu_rdata_idle", bus.lsu_rdata, 32'd0);

      if (exp_resp) begin
        in_flight = 1'b0;
        if (exp_lsu) begin
          if (bus.ifu_reqValid) owed = 1'b1;
          locked = bus.lsu_lock && (lat_mode != 2);
        end else owed = 1'b0;
      end else if (exp_active) begin
        in_flight = 1'b1; owner_lsu = exp_lsu;
      end else if (locked && !bus.lsu_lock) locked = 1'b0;
    end
  end

  task automatic issue_ifu(input logic [31:0] a);
    bus.ifu_addr = a;
    ifu_q.push_back(exp_data(a));
    ifu_pend = 1'b1;
    bus.ifu_reqValid = 1'b1;
  endtask

  task automatic issue_lsu(input logic [31:0] a, input logic lk);
    bus.lsu_addr  = a;
    bus.lsu_wdata = $urandom;
    bus.lsu_size  = 2'($urandom_range(0, 3));
    bus.lsu_wen   = 1'($urandom_range(0, 1));
    bus.lsu_wmask = 4'($urandom_range(0, 15));
    bus.lsu_lock  = lk;
    lsu_q.push_back(exp_data(a));
    lsu_pend = 1'b1;
    bus.lsu_reqValid = 1'b1;
  endtask

  // One cycle of master behaviour; a locked LSU beat is always followed by its second beat
  task automatic step(input int p_ifu, input int p_lsu, input bit allow_lock);
    @(posedge clock); #1;
    if (ifu_pend && ifu_resp_n != ifu_seen) begin
      ifu_seen = ifu_resp_n; ifu_pend = 1'b0; bus.ifu_reqValid = 1'b0;
    end
    if (lsu_pend && lsu_resp_n != lsu_seen) begin
      lsu_seen = lsu_resp_n; lsu_pend = 1'b0; bus.lsu_reqValid = 1'b0;
      if (bus.lsu_lock) issue_lsu((bus.lsu_addr & ~32'd3) + 32'd4, 1'b0);
    end
    if (!ifu_pend && int'($urandom_range(0, 99)) < p_ifu) issue_ifu($urandom & ~32'd3);
    if (!lsu_pend && int'($urandom_range(0, 99)) < p_lsu)
      issue_lsu($urandom, allow_lock && ($urandom_range(0, 3) == 0));
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((ifu_pend || lsu_pend) && n < 300) begin
      step(0, 0, 1'b0);
      n++;
    end
    check(name, 32'(ifu_pend || lsu_pend), 32'd0);
    check({name, "_queues"}, 32'(ifu_q.size() + lsu_q.size()), 32'd0);
  endtask

  initial begin : global_bound
    #400000;
    $display("FAIL global_timeout: got no finish expected finish within 400000 time units");
    $fatal(1, "bench time limit");
  end

  initial begin : main
    int k, start;
    logic [31:0] s;
    bus.ifu_reqValid = 1'b0; bus.ifu_addr = '0;
    bus.lsu_reqValid = 1'b0; bus.lsu_lock = 1'b0; bus.lsu_addr = '0; bus.lsu_wdata = '0;
    bus.lsu_size = 2'b00; bus.lsu_wen = 1'b0; bus.lsu_wmask = 4'h0;

    repeat (2) @(posedge clock);
    #1 check("reset_outputs", {28'd0, bus.mem_reqValid, bus.ifu_respValid, bus.lsu_respValid, bus.bus_err}, 32'd0);
    @(negedge clock) reset = 1'b0;
    #2 check("idle_outputs", bus.mem_addr | bus.mem_wdata | bus.ifu_rdata | bus.lsu_rdata |
                             {25'd0, bus.mem_size, bus.mem_wen, bus.mem_wmask}, 32'd0);
    mon_en = 1'b1;

    // Lone fetch, memory answers three cycles after the grant
    lat_mode = 4;
    @(posedge clock); #1 issue_ifu(32'h8000_0000);
    k = 0;
    do begin
      step(0, 0, 1'b0);
      k++;
    end while (ifu_pend && k < 20);
    check("ifu_latency", 32'(k), 32'd4);

    // Simultaneous requests with a split LSU access: LSU, LSU beat 2, then IFU
    lat_mode = 0;
    seq.delete();
    @(posedge clock); #1;
    issue_ifu(32'h0000_2000);
    issue_lsu(32'h0000_0101, 1'b1);
    drain("lock_drain");
    s = '0;
    foreach (seq[i]) s = {s[30:0], seq[i]};
    check("lock_order_len", 32'(seq.size()), 32'd3);
    check("lock_order", s, 32'b110);

    repeat (600) step(40, 40, 1'b1);
    drain("rand_drain");

    // Zero-latency memory: back-to-back fetches complete once per cycle
    lat_mode = 1;
    start = ifu_resp_n;
    repeat (50) step(100, 0, 1'b0);
    drain("zl_drain");
    check("zl_count", 32'(ifu_resp_n - start), 32'd50);
    repeat (200) step(50, 50, 1'b1);
    drain("zl_mix_drain");

    // Memory never answers: every request ends through the watchdog
    lat_mode = 2;
    repeat (300) step(30, 30, 1'b0);
    drain("hang_drain");

    // Reset while the LSU owns the port, then a stale memory response
    @(posedge clock); #1 issue_lsu(32'h0000_4000, 1'b0);
    step(0, 0, 1'b0);
    step(0, 0, 1'b0);
    #2;
    reset = 1'b1; mon_en = 1'b0;
    bus.ifu_reqValid = 1'b0; bus.lsu_reqValid = 1'b0; bus.lsu_lock = 1'b0;
    ifu_pend = 1'b0; lsu_pend = 1'b0;
    ifu_q.delete(); lsu_q.delete();
    #1 check("reset_mid", {28'd0, bus.mem_reqValid, bus.ifu_respValid, bus.lsu_respValid, bus.bus_err}, 32'd0);
    @(posedge clock); #1;
    reset = 1'b0; lat_mode = 3; man_resp = 1'b1;
    @(negedge clock); #2;
    check("late_resp", {28'd0, bus.mem_reqValid, bus.ifu_respValid, bus.lsu_respValid, bus.bus_err}, 32'd0);
    check("late_rdata", bus.ifu_rdata | bus.lsu_rdata, 32'd0);
    @(posedge clock); #1;
    man_resp = 1'b0; lat_mode = 0;
    ifu_seen = ifu_resp_n; lsu_seen = lsu_resp_n;
    mon_en = 1'b1;
    @(posedge clock); #1 issue_ifu(32'h0000_0040);
    drain("post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
